// File: rtl/valve_policy_reader.sv
`default_nettype none
// ============================================================================
//  Module      : valve_policy_reader
//  Description : Policy-table responder. Looks up a 9-bit policy address and
//                slews the registered valve command toward the stored target.
//  Revision    : 1.0  initial release
// ============================================================================
module valve_policy_reader #(
    parameter int          ADDR_W        = 9,
    parameter int          DATA_W        = 6,
    parameter int          STEP          = 1,
    parameter int unsigned DEFAULT_VALVE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic              addr_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              ready,
    output logic [DATA_W-1:0] valve_out,
    output logic              lookup_done,
    output logic              miss,
    output logic              addr_err,
    output logic              wr_err
);

    localparam int              c_FIELDS  = ADDR_W / 3;
    localparam int              c_DEPTH   = 2 ** ADDR_W;
    localparam logic [DATA_W:0] c_STEP    = (DATA_W + 1)'(STEP);
    localparam logic [DATA_W-1:0] c_DEFAULT = DATA_W'(DEFAULT_VALVE);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_SLEW = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [DATA_W-1:0]   r_valve, w_valve_nxt;
    logic [DATA_W-1:0]   r_target, w_target_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [DATA_W-1:0]   r_rd_data;
    logic [DATA_W-1:0]   r_mem [0:c_DEPTH-1];
    logic [c_DEPTH-1:0]  r_valid;
    logic                r_done, w_done_nxt;
    logic                r_miss, w_miss_nxt;
    logic                r_addr_err, w_addr_err_nxt;
    logic                r_wr_err, w_wr_err_nxt;
    logic                w_accept;
    logic                w_wr_do;
    logic [c_FIELDS-1:0] w_field_ok;
    logic                w_addr_ok;
    logic                w_up;
    logic [DATA_W-1:0]   w_dist;
    logic                w_close;

    // Every 3-bit field of the policy address must lie in 1..3.
    for (genvar g = 0; g < c_FIELDS; g++) begin : g_field
        assign w_field_ok[g] = (addr_in[3*g +: 3] != 3'd0) && (addr_in[3*g +: 3] <= 3'd3);
    end
    assign w_addr_ok = &w_field_ok;

    assign w_up    = (r_target >= r_valve);
    assign w_dist  = w_up ? (r_target - r_valve) : (r_valve - r_target);
    assign w_close = ({1'b0, w_dist} <= c_STEP);

    always_comb begin
        w_state_nxt    = r_state;
        w_valve_nxt    = r_valve;
        w_target_nxt   = r_target;
        w_addr_nxt     = r_addr;
        w_done_nxt     = 1'b0;
        w_miss_nxt     = 1'b0;
        w_addr_err_nxt = 1'b0;
        w_wr_err_nxt   = 1'b0;
        w_accept       = 1'b0;
        w_wr_do        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (wr_en) begin
                    w_wr_do = 1'b1;
                end else if (addr_valid) begin
                    if (w_addr_ok) begin
                        w_accept    = 1'b1;
                        w_addr_nxt  = addr_in;
                        w_state_nxt = S_READ;
                    end else begin
                        w_addr_err_nxt = 1'b1;
                    end
                end
            end
            S_READ: begin
                w_wr_err_nxt = wr_en;
                if (r_valid[r_addr]) begin
                    w_target_nxt = r_rd_data;
                end else begin
                    w_target_nxt = c_DEFAULT;
                    w_miss_nxt   = 1'b1;
                end
                w_state_nxt = S_SLEW;
            end
            S_SLEW: begin
                w_wr_err_nxt = wr_en;
                if (w_close) begin
                    w_valve_nxt = r_target;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_up) begin
                    w_valve_nxt = r_valve + c_STEP[DATA_W-1:0];
                end else begin
                    w_valve_nxt = r_valve - c_STEP[DATA_W-1:0];
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valve    <= c_DEFAULT;
            r_target   <= c_DEFAULT;
            r_addr     <= '0;
            r_done     <= 1'b0;
            r_miss     <= 1'b0;
            r_addr_err <= 1'b0;
            r_wr_err   <= 1'b0;
            r_valid    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_valve    <= w_valve_nxt;
            r_target   <= w_target_nxt;
            r_addr     <= w_addr_nxt;
            r_done     <= w_done_nxt;
            r_miss     <= w_miss_nxt;
            r_addr_err <= w_addr_err_nxt;
            r_wr_err   <= w_wr_err_nxt;
            if (w_wr_do) begin
                r_valid[wr_addr] <= 1'b1;
            end
        end
    end

    // Table contents survive reset; only the valid bits are cleared.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_do) begin
            r_mem[wr_addr] <= wr_data;
        end
        if (w_accept) begin
            r_rd_data <= r_mem[addr_in];
        end
    end

    assign ready       = (r_state == S_IDLE);
    assign valve_out   = r_valve;
    assign lookup_done = r_done;
    assign miss        = r_miss;
    assign addr_err    = r_addr_err;
    assign wr_err      = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_valve_policy_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_valve_policy_reader
//  Description : Drives two valve_policy_reader instances (STEP 1 and 4) with
//                shared stimulus and compares against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_valve_policy_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       addr_valid;
    logic       wr_en;
    logic [8:0] addr_in;
    logic [8:0] wr_addr;
    logic [5:0] wr_data;

    logic       rdy  [2];
    logic [5:0] vo   [2];
    logic       done [2];
    logic       mis  [2];
    logic       aerr [2];
    logic       werr [2];

    int n_checks = 0;
    int n_errors = 0;

    int mmem   [512];
    bit mvalid [512];
    int mvalve [2];

    always #5 clk = ~clk;

    valve_policy_reader #(.ADDR_W(9), .DATA_W(6), .STEP(1), .DEFAULT_VALVE(0)) u_dut_s1 (
        .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(rdy[0]), .valve_out(vo[0]), .lookup_done(done[0]), .miss(mis[0]),
        .addr_err(aerr[0]), .wr_err(werr[0])
    );

    valve_policy_reader #(.ADDR_W(9), .DATA_W(6), .STEP(4), .DEFAULT_VALVE(0)) u_dut_s4 (
        .clk(clk), .rst(rst), .addr_in(addr_in), .addr_valid(addr_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(rdy[1]), .valve_out(vo[1]), .lookup_done(done[1]), .miss(mis[1]),
        .addr_err(aerr[1]), .wr_err(werr[1])
    );

    function automatic int step_of(input int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic bit is_legal(input logic [8:0] a);
        int f;
        for (int i = 0; i < 3; i++) begin
            f = (int'(a) >> (3 * i)) % 8;
            if (f < 1 || f > 3) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic logic [8:0] rand_legal();
        logic [8:0] a;
        a[8:6] = 3'($urandom_range(1, 3));
        a[5:3] = 3'($urandom_range(1, 3));
        a[2:0] = 3'($urandom_range(1, 3));
        return a;
    endfunction

    function automatic logic [8:0] rand_illegal();
        logic [8:0] a;
        a = 9'($urandom);
        while (is_legal(a)) a = 9'($urandom);
        return a;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 512; i++) mvalid[i] = 1'b0;
        mvalve[0] = 0;
        mvalve[1] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_valve[%0d]", k), int'(vo[k]), 0);
            check($sformatf("rst_ready[%0d]", k), int'(rdy[k]), 1);
            check($sformatf("rst_done[%0d]", k), int'(done[k]), 0);
            check($sformatf("rst_miss[%0d]", k), int'(mis[k]), 0);
            check($sformatf("rst_pulses[%0d]", k), int'(aerr[k]) + int'(werr[k]), 0);
        end
    endtask

    task automatic do_write(input logic [8:0] a, input int d, input bit with_req);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = 6'(d);
        if (with_req) begin
            addr_valid = 1'b1;
            addr_in    = rand_legal();
        end
        @(negedge clk);
        wr_en      = 1'b0;
        addr_valid = 1'b0;
        mmem[a]   = d;
        mvalid[a] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("wr_ready[%0d]", k), int'(rdy[k]), 1);
            check($sformatf("wr_noerr[%0d]", k), int'(werr[k]) + int'(aerr[k]), 0);
        end
    endtask

    task automatic do_bad(input logic [8:0] a);
        @(negedge clk);
        addr_valid = 1'b1;
        addr_in    = a;
        @(negedge clk);
        addr_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("aerr_pulse[%0d]", k), int'(aerr[k]), 1);
            check($sformatf("aerr_ready[%0d]", k), int'(rdy[k]), 1);
            check($sformatf("aerr_valve[%0d]", k), int'(vo[k]), mvalve[k]);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++)
            check($sformatf("aerr_clear[%0d]", k), int'(aerr[k]), 0);
    endtask

    // inj: 0 none, 1 write attempt in READ, 2 write attempt in first SLEW cycle.
    // abort_at: assert rst after that many slew cycles (0 = never).
    task automatic do_lookup(input logic [8:0] a, input int inj, input int abort_at);
        int  t;
        int  d;
        int  s;
        bit  ismiss;
        bit  fin [2];
        bit  was;
        int  i;
        t      = mvalid[a] ? mmem[a] : 0;
        ismiss = !mvalid[a];
        fin[0] = 1'b0;
        fin[1] = 1'b0;
        @(negedge clk);
        addr_in    = a;
        addr_valid = 1'b1;
        @(negedge clk);
        addr_valid = 1'b0;
        for (int k = 0; k < 2; k++)
            check($sformatf("lk_busy1[%0d]", k), int'(rdy[k]), 0);
        if (inj == 1) begin
            wr_en   = 1'b1;
            wr_addr = a;
            wr_data = 6'(t ^ 21);
        end else if ($urandom_range(0, 1) == 1) begin
            addr_valid = 1'b1;
            addr_in    = rand_legal();
        end
        @(negedge clk);
        wr_en      = 1'b0;
        addr_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("lk_miss[%0d]", k), int'(mis[k]), int'(ismiss));
            check($sformatf("lk_werr_rd[%0d]", k), int'(werr[k]), (inj == 1) ? 1 : 0);
            check($sformatf("lk_busy2[%0d]", k), int'(rdy[k]), 0);
        end
        if (inj == 2) begin
            wr_en   = 1'b1;
            wr_addr = a;
            wr_data = 6'(t ^ 42);
        end
        for (i = 1; i <= 70 && !(fin[0] && fin[1]); i++) begin
            @(negedge clk);
            wr_en = 1'b0;
            for (int k = 0; k < 2; k++) begin
                was = fin[k];
                if (!was) begin
                    s = step_of(k);
                    d = t - mvalve[k];
                    if (d <= s && d >= -s) begin
                        mvalve[k] = t;
                        fin[k]    = 1'b1;
                    end else begin
                        mvalve[k] = mvalve[k] + ((d > 0) ? s : -s);
                    end
                end
                check($sformatf("lk_valve[%0d] c%0d", k, i), int'(vo[k]), mvalve[k]);
                check($sformatf("lk_done[%0d] c%0d", k, i), int'(done[k]), (fin[k] && !was) ? 1 : 0);
                check($sformatf("lk_ready[%0d] c%0d", k, i), int'(rdy[k]), int'(fin[k]));
                if (i == 1) begin
                    check($sformatf("lk_miss_end[%0d]", k), int'(mis[k]), 0);
                    check($sformatf("lk_werr_sl[%0d]", k), int'(werr[k]), (inj == 2) ? 1 : 0);
                end
            end
            if (abort_at == i && !(fin[0] && fin[1])) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                model_reset();
                for (int k = 0; k < 2; k++) begin
                    check($sformatf("abort_valve[%0d]", k), int'(vo[k]), 0);
                    check($sformatf("abort_ready[%0d]", k), int'(rdy[k]), 1);
                    check($sformatf("abort_done[%0d]", k), int'(done[k]), 0);
                end
                return;
            end
        end
        if (!(fin[0] && fin[1])) check("lk_timeout", 0, 1);
    endtask

    initial begin
        int r;
        logic [8:0] a;
        rst        = 1'b1;
        addr_valid = 1'b0;
        wr_en      = 1'b0;
        addr_in    = '0;
        wr_addr    = '0;
        wr_data    = '0;
        for (int i = 0; i < 512; i++) mmem[i] = 0;
        repeat (2) @(negedge clk);
        do_reset();

        do_lookup(9'b001_001_001, 0, 0);
        do_write(9'b010_010_010, 5, 1'b0);
        do_lookup(9'b010_010_010, 0, 0);
        do_write(9'b011_011_011, 63, 1'b0);
        do_lookup(9'b011_011_011, 0, 0);
        do_bad(9'b000_010_011);
        do_bad(9'b100_001_001);
        do_write(9'b001_001_010, 17, 1'b1);
        do_lookup(9'b010_010_010, 2, 0);
        do_lookup(9'b010_010_010, 1, 0);
        do_lookup(9'b010_010_010, 0, 0);
        do_lookup(9'b001_001_001, 0, 0);
        do_reset();
        do_write(9'b001_010_011, 20, 1'b0);
        do_lookup(9'b001_010_011, 0, 3);
        do_lookup(9'b001_010_011, 0, 0);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 50) begin
                r = $urandom_range(0, 99);
                do_lookup(rand_legal(), (r < 10) ? 1 : (r < 20) ? 2 : 0,
                          (r >= 95) ? $urandom_range(1, 10) : 0);
            end else if (r < 78) begin
                a = ($urandom_range(0, 9) == 0) ? rand_illegal() : rand_legal();
                do_write(a, $urandom_range(0, 63), $urandom_range(0, 4) == 0);
            end else if (r < 95) begin
                do_bad(rand_illegal());
            end else begin
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
